// File: rtl/kulisch_acc_stage.sv
// kulisch_acc_stage
//   Exact (Kulisch-style) accumulator for the dot-product lane. Each term arrives
//   in carry-save form from the Booth/Wallace multiplier. The stage resolves the
//   product, sign-extends it, aligns it by a per-term left shift and adds it into
//   a wide two's-complement register. One result is emitted per group of terms,
//   and a group is closed by in_last.
//
//   Pipeline (term accepted at edge N):
//     N   : input capture
//     N+1 : S1  p = sum + carry (mod 2^PROD_W), illegal-shift flag
//     N+2 : S2  a = sext(p) << shift (0 if shift is illegal)
//     N+3 : S3  acc += a, sticky overflow; the last term also loads the outputs
//
// Ports
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset
//   clear         synchronous abort: flush the pipeline and zero the accumulator
//   in_valid      term valid
//   in_ready      term accepted when in_valid & in_ready
//   in_sum        carry-save sum row
//   in_carry      carry-save carry row (already weight-aligned)
//   in_shift      left shift applied to this term
//   in_last       final term of the group
//   out_valid     result valid, held until out_ready
//   out_ready     downstream accepts the result
//   out_acc       accumulated group result, signed
//   out_overflow  the group overflowed or contained an illegal shift
module kulisch_acc_stage #(
  parameter int PROD_W  = 22,
  parameter int SHIFT_W = 7,
  parameter int ACC_W   = 96
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PROD_W-1:0]  in_sum,
  input  logic [PROD_W-1:0]  in_carry,
  input  logic [SHIFT_W-1:0] in_shift,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_acc,
  output logic               out_overflow
);

  localparam int MAX_SH = ACC_W - PROD_W;
  localparam int EXT_W  = ACC_W - PROD_W;
  localparam logic [SHIFT_W-1:0] MAX_SH_W = SHIFT_W'(MAX_SH);

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    DRAIN  = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Input capture
  logic               r0_valid_q;
  logic [PROD_W-1:0]  r0_sum_q;
  logic [PROD_W-1:0]  r0_carry_q;
  logic [SHIFT_W-1:0] r0_shift_q;
  logic               r0_last_q;

  // S1: resolved product
  logic               s1_valid_q;
  logic [PROD_W-1:0]  s1_p_q;
  logic [SHIFT_W-1:0] s1_shift_q;
  logic               s1_last_q;
  logic               s1_ill_q;

  // S2: aligned addend
  logic               s2_valid_q;
  logic [ACC_W-1:0]   s2_a_q;
  logic               s2_last_q;
  logic               s2_ill_q;

  // S3: accumulator
  logic [ACC_W-1:0]   acc_q;
  logic               ovf_q;

  logic               in_ready_q;
  logic               out_valid_q;
  logic [ACC_W-1:0]   out_acc_q;
  logic               out_ovf_q;

  // Combinational next values
  logic               accept;
  logic [PROD_W-1:0]  p_d;
  logic               ill_d;
  logic [ACC_W-1:0]   a_ext;
  logic [ACC_W-1:0]   a_d;
  logic [ACC_W-1:0]   acc_sum;
  logic               add_ovf;
  logic [ACC_W-1:0]   acc_d;
  logic               ovf_d;
  logic               group_done;
  logic               handshake;

  always_comb begin
    accept  = in_valid && in_ready_q && !clear;
    p_d     = r0_sum_q + r0_carry_q;
    ill_d   = (r0_shift_q > MAX_SH_W);
    a_ext   = {{EXT_W{s1_p_q[PROD_W-1]}}, s1_p_q};
    a_d     = s1_ill_q ? '0 : (a_ext << s1_shift_q);
    acc_sum = acc_q + s2_a_q;
    // Signed overflow: both operands share a sign that the result does not
    add_ovf = (acc_q[ACC_W-1] == s2_a_q[ACC_W-1]) &&
              (acc_sum[ACC_W-1] != acc_q[ACC_W-1]);
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    if (s2_valid_q) begin
      acc_d = acc_sum;
      ovf_d = ovf_q | add_ovf | s2_ill_q;
    end
    group_done = s2_valid_q && s2_last_q;
    handshake  = out_valid_q && out_ready;

    state_d = state_q;
    case (state_q)
      ACCUM:   if (accept && in_last) state_d = DRAIN;
      DRAIN:   if (group_done)        state_d = OUTPUT;
      OUTPUT:  if (handshake)         state_d = ACCUM;
      default:                        state_d = ACCUM;
    endcase
    if (clear) state_d = ACCUM;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      r0_valid_q  <= 1'b0;
      r0_sum_q    <= '0;
      r0_carry_q  <= '0;
      r0_shift_q  <= '0;
      r0_last_q   <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_p_q      <= '0;
      s1_shift_q  <= '0;
      s1_last_q   <= 1'b0;
      s1_ill_q    <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_a_q      <= '0;
      s2_last_q   <= 1'b0;
      s2_ill_q    <= 1'b0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d == ACCUM);

      // Datapath registers load unconditionally; only the valids gate effect
      r0_sum_q   <= in_sum;
      r0_carry_q <= in_carry;
      r0_shift_q <= in_shift;
      r0_last_q  <= in_last;
      s1_p_q     <= p_d;
      s1_shift_q <= r0_shift_q;
      s1_last_q  <= r0_last_q;
      s1_ill_q   <= ill_d;
      s2_a_q     <= a_d;
      s2_last_q  <= s1_last_q;
      s2_ill_q   <= s1_ill_q;

      if (clear) begin
        r0_valid_q  <= 1'b0;
        s1_valid_q  <= 1'b0;
        s2_valid_q  <= 1'b0;
        acc_q       <= '0;
        ovf_q       <= 1'b0;
        out_valid_q <= 1'b0;
      end else begin
        r0_valid_q <= accept;
        s1_valid_q <= r0_valid_q;
        s2_valid_q <= s1_valid_q;
        acc_q      <= acc_d;
        ovf_q      <= ovf_d;

        if (state_q == DRAIN && group_done) begin
          out_valid_q <= 1'b1;
          out_acc_q   <= acc_d;
          out_ovf_q   <= ovf_d;
        end

        // The pipeline is empty in OUTPUT, so zeroing acc cannot lose a term
        if (state_q == OUTPUT && handshake) begin
          out_valid_q <= 1'b0;
          acc_q       <= '0;
          ovf_q       <= 1'b0;
        end
      end
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_acc      = out_acc_q;
  assign out_overflow = out_ovf_q;

endmodule

// File: tb/tb_kulisch_acc_stage.sv
module tb_kulisch_acc_stage;

  localparam int PROD_W  = 22;
  localparam int SHIFT_W = 7;
  localparam int ACC_W   = 96;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               clear;
  logic               in_valid;
  logic               in_ready;
  logic [PROD_W-1:0]  in_sum;
  logic [PROD_W-1:0]  in_carry;
  logic [SHIFT_W-1:0] in_shift;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [ACC_W-1:0]   out_acc;
  logic               out_overflow;

  int total = 0;
  int bad   = 0;

  kulisch_acc_stage #(
    .PROD_W (PROD_W),
    .SHIFT_W(SHIFT_W),
    .ACC_W  (ACC_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sum      (in_sum),
    .in_carry    (in_carry),
    .in_shift    (in_shift),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_acc     (out_acc),
    .out_overflow(out_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [ACC_W-1:0] obs,
                       input logic [ACC_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one term for exactly one edge; in_valid stays high for chaining.
  task automatic push(input logic [PROD_W-1:0] s, input logic [PROD_W-1:0] c,
                      input logic [SHIFT_W-1:0] sh, input logic last);
    in_valid = 1'b1;
    in_sum   = s;
    in_carry = c;
    in_shift = sh;
    in_last  = last;
    step();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Bounded wait for out_valid; returns number of edges waited.
  task automatic wait_out(input string tag, output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      step();
      cyc++;
    end
    check({tag, "_valid"}, ACC_W'(out_valid), ACC_W'(1));
  endtask

  initial begin
    int cyc;
    int seen;
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_sum    = '0;
    in_carry  = '0;
    in_shift  = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    // Reset state
    #3;
    check("rst_out_valid", ACC_W'(out_valid), '0);
    check("rst_out_acc", out_acc, '0);
    check("rst_out_ovf", ACC_W'(out_overflow), '0);
    #20;
    rst_n = 1'b1;
    step();
    check("rst_in_ready", ACC_W'(in_ready), ACC_W'(1));

    // T1: 5 + 3, one-term group, latency 3
    push(22'h000005, 22'h000003, 7'd0, 1'b1);
    idle();
    check("t1_in_ready_drain", ACC_W'(in_ready), '0);
    wait_out("t1", cyc);
    check("t1_latency", ACC_W'(cyc), ACC_W'(3));
    check("t1_acc", out_acc, ACC_W'(8));
    check("t1_ovf", ACC_W'(out_overflow), '0);
    step();
    check("t1_valid_drop", ACC_W'(out_valid), '0);
    check("t1_in_ready_back", ACC_W'(in_ready), ACC_W'(1));

    // T2: (-1 << 4) + 32 back-to-back
    push(22'h3FFFFF, 22'h000000, 7'd4, 1'b0);
    push(22'h000020, 22'h000000, 7'd0, 1'b1);
    idle();
    wait_out("t2", cyc);
    check("t2_acc", out_acc, ACC_W'(16));
    check("t2_ovf", ACC_W'(out_overflow), '0);
    step();

    // T3: backpressure holds the result and blocks inputs
    out_ready = 1'b0;
    push(22'h000005, 22'h000003, 7'd0, 1'b1);
    idle();
    wait_out("t3", cyc);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      in_sum   = 22'h000009;
      in_last  = 1'b1;
      step();
      check($sformatf("t3_hold_valid_%0d", i), ACC_W'(out_valid), ACC_W'(1));
      check($sformatf("t3_hold_acc_%0d", i), out_acc, ACC_W'(8));
      check($sformatf("t3_hold_ready_%0d", i), ACC_W'(in_ready), '0);
    end
    idle();
    out_ready = 1'b1;
    step();
    check("t3_valid_drop", ACC_W'(out_valid), '0);
    check("t3_in_ready_back", ACC_W'(in_ready), ACC_W'(1));
    push(22'h000001, 22'h000001, 7'd0, 1'b1);
    idle();
    wait_out("t3b", cyc);
    check("t3b_acc_from_zero", out_acc, ACC_W'(2));
    step();

    // T4: two max-positive terms at shift 74 overflow; 2*(2^21-1)*2^74 = 2^96-2^75
    push(22'h1FFFFF, 22'h000000, 7'd74, 1'b0);
    push(22'h1FFFFF, 22'h000000, 7'd74, 1'b1);
    idle();
    wait_out("t4", cyc);
    check("t4_acc", out_acc, 96'hFFFFF8000000000000000000);
    check("t4_ovf", ACC_W'(out_overflow), ACC_W'(1));
    step();
    // Illegal shift: the term contributes zero but flags overflow
    push(22'h000005, 22'h000000, 7'd75, 1'b1);
    idle();
    wait_out("t4b", cyc);
    check("t4b_acc", out_acc, '0);
    check("t4b_ovf", ACC_W'(out_overflow), ACC_W'(1));
    step();

    // T5: clear flushes three in-flight terms; the term presented with clear is dropped
    push(22'h000064, 22'h000000, 7'd0, 1'b0);
    push(22'h000065, 22'h000000, 7'd1, 1'b0);
    push(22'h000066, 22'h000000, 7'd2, 1'b0);
    clear = 1'b1;
    push(22'h000100, 22'h000000, 7'd0, 1'b1);
    clear = 1'b0;
    idle();
    check("t5_ready_after_clear", ACC_W'(in_ready), ACC_W'(1));
    push(22'h000007, 22'h000000, 7'd0, 1'b1);
    idle();
    wait_out("t5", cyc);
    check("t5_acc_no_residue", out_acc, ACC_W'(7));
    check("t5_ovf", ACC_W'(out_overflow), '0);
    step();
    // clear during OUTPUT, together with out_ready
    out_ready = 1'b0;
    push(22'h000004, 22'h000000, 7'd0, 1'b1);
    idle();
    wait_out("t5b", cyc);
    check("t5b_acc", out_acc, ACC_W'(4));
    out_ready = 1'b1;
    clear     = 1'b1;
    step();
    clear = 1'b0;
    check("t5b_valid_dropped", ACC_W'(out_valid), '0);
    check("t5b_in_ready", ACC_W'(in_ready), ACC_W'(1));
    push(22'h000003, 22'h000000, 7'd0, 1'b1);
    idle();
    wait_out("t5c", cyc);
    check("t5c_acc", out_acc, ACC_W'(3));
    step();

    // T6: asynchronous reset in the middle of DRAIN
    push(22'h000001, 22'h000000, 7'd0, 1'b0);
    push(22'h000002, 22'h000000, 7'd0, 1'b1);
    idle();
    step();
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", ACC_W'(out_valid), '0);
    check("t6_rst_acc", out_acc, '0);
    check("t6_rst_ovf", ACC_W'(out_overflow), '0);
    check("t6_rst_ready", ACC_W'(in_ready), '0);
    #12;
    rst_n = 1'b1;
    step();
    check("t6_in_ready", ACC_W'(in_ready), ACC_W'(1));
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) seen++;
      step();
    end
    check("t6_no_stale_output", ACC_W'(seen), '0);
    push(22'h000005, 22'h000003, 7'd0, 1'b1);
    idle();
    wait_out("t6", cyc);
    check("t6_latency", ACC_W'(cyc), ACC_W'(3));
    check("t6_acc", out_acc, ACC_W'(8));
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
